// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing generator.
// The h/v counters form the fetch stage: fetch_* is their combinational decode,
// so a pixel source gets one cycle to respond. de/hs/vs/x/y/frame_start are the
// registered decode of the counters, exactly one clock behind the matching fetch_*.
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        fetch_valid,
    output logic [10:0] fetch_x,
    output logic [10:0] fetch_y,
    output logic        de,
    output logic        hs,
    output logic        vs,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start
);

    // Totals must not exceed 2048 so that the last count fits the 11-bit counters.
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // 12-bit boundaries so a limit of exactly 2048 still compares correctly.
    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);

    // Counter value strictly below a limit.
    function automatic logic below(input logic [10:0] cnt, input logic [11:0] lim);
        return {1'b0, cnt} < lim;
    endfunction

    // Counter value inside the half-open window [lo, hi).
    function automatic logic in_window(input logic [10:0] cnt,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
        return ({1'b0, cnt} >= lo) && ({1'b0, cnt} < hi);
    endfunction

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        frame_start_q, frame_start_d;

    // Next-state of the raster counters and decode of the current position.
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 11'd1;
        end

        fetch_valid   = below(h_cnt_q, H_ACT_C) && below(v_cnt_q, V_ACT_C);
        de_d          = fetch_valid;
        hs_d          = in_window(h_cnt_q, HS_BEG_C, HS_END_C) ? HS_POL : ~HS_POL;
        vs_d          = in_window(v_cnt_q, VS_BEG_C, VS_END_C) ? VS_POL : ~VS_POL;
        x_d           = h_cnt_q;
        y_d           = v_cnt_q;
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Stage 0: raster position counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 1: display outputs, one clock behind the fetch position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_q          <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fetch_x     = h_cnt_q;
    assign fetch_y     = v_cnt_q;
    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default, reduced-size and tiny inverted-polarity
// instances share one clock and reset; outputs are compared against a raster
// model computed from the cycle count since reset release.
`timescale 1ns/1ps
module tb_video_timing_gen;

    typedef struct packed {
        logic        fv;
        logic [10:0] fx;
        logic [10:0] fy;
        logic        de;
        logic        hs;
        logic        vs;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Edges seen since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    logic d_fv, d_de, d_hs, d_vs, d_fs;
    logic [10:0] d_fx, d_fy, d_x, d_y;
    logic m_fv, m_de, m_hs, m_vs, m_fs;
    logic [10:0] m_fx, m_fy, m_x, m_y;
    logic t_fv, t_de, t_hs, t_vs, t_fs;
    logic [10:0] t_fx, t_fy, t_x, t_y;
    obs_t o_def, o_mid, o_tiny;

    video_timing_gen u_def (
        .clk(clk), .reset_n(reset_n), .fetch_valid(d_fv), .fetch_x(d_fx), .fetch_y(d_fy),
        .de(d_de), .hs(d_hs), .vs(d_vs), .x(d_x), .y(d_y), .frame_start(d_fs));

    video_timing_gen #(
        .H_ACTIVE(40), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_ACTIVE(30), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_mid (
        .clk(clk), .reset_n(reset_n), .fetch_valid(m_fv), .fetch_x(m_fx), .fetch_y(m_fy),
        .de(m_de), .hs(m_hs), .vs(m_vs), .x(m_x), .y(m_y), .frame_start(m_fs));

    video_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_tiny (
        .clk(clk), .reset_n(reset_n), .fetch_valid(t_fv), .fetch_x(t_fx), .fetch_y(t_fy),
        .de(t_de), .hs(t_hs), .vs(t_vs), .x(t_x), .y(t_y), .frame_start(t_fs));

    assign o_def  = {d_fv, d_fx, d_fy, d_de, d_hs, d_vs, d_x, d_y, d_fs};
    assign o_mid  = {m_fv, m_fx, m_fy, m_de, m_hs, m_vs, m_x, m_y, m_fs};
    assign o_tiny = {t_fv, t_fx, t_fy, t_de, t_hs, t_vs, t_x, t_y, t_fs};

    // Raster model: after cyc edges the counters sit at position cyc mod frame
    // size and the display outputs show the position one edge earlier.
    function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp, input bit in_rst, input int cyc);
        obs_t o;
        int ht, vt, q, p, px, py;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        o = '0;
        o.hs = !hp;
        o.vs = !vp;
        o.fv = 1'b1;
        if (in_rst) return o;
        q = cyc % (ht * vt);
        o.fx = 11'(q % ht);
        o.fy = 11'(q / ht);
        o.fv = ((q % ht) < ha) && ((q / ht) < va);
        if (cyc == 0) return o;
        p  = (cyc - 1) % (ht * vt);
        px = p % ht;
        py = p / ht;
        o.x  = 11'(px);
        o.y  = 11'(py);
        o.de = (px < ha) && (py < va);
        o.hs = (px >= ha + hf && px < ha + hf + hsw) ? hp : !hp;
        o.vs = (py >= va + vf && py < va + vf + vsw) ? vp : !vp;
        o.fs = (p == 0);
        return o;
    endfunction

    function automatic obs_t mk(input logic fv, input int fx, input int fy, input logic de,
                                input logic hs, input logic vs, input int xx, input int yy,
                                input logic fs);
        obs_t o;
        o.fv = fv; o.fx = 11'(fx); o.fy = 11'(fy);
        o.de = de; o.hs = hs; o.vs = vs;
        o.x = 11'(xx); o.y = 11'(yy); o.fs = fs;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    task automatic check_models();
        chk("def_model",  o_def,  model(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, !reset_n, n));
        chk("mid_model",  o_mid,  model(40, 3, 4, 5, 30, 2, 3, 4, 1'b1, 1'b1, !reset_n, n));
        chk("tiny_model", o_tiny, model(4, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0, !reset_n, n));
    endtask

    vec_t tbl [13];

    int de_cnt, de_xmin, de_xmax, hs_cnt, hs_xmin, hs_xmax, line_per;
    int vs_cnt, vs_ymin, vs_ymax, mde_lines, fs_cnt, fs_per, ychg_bad;
    bit de_line [64];
    logic [10:0] prev_my, prev_dy;
    bit found;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Tiny instance: H_TOTAL=7, V_TOTAL=5, active-low syncs.
        tbl[0]  = '{1,  mk(1, 1, 0, 1, 1, 1, 0, 0, 1)};
        tbl[1]  = '{4,  mk(0, 4, 0, 1, 1, 1, 3, 0, 0)};
        tbl[2]  = '{5,  mk(0, 5, 0, 0, 1, 1, 4, 0, 0)};
        tbl[3]  = '{6,  mk(0, 6, 0, 0, 0, 1, 5, 0, 0)};
        tbl[4]  = '{7,  mk(1, 0, 1, 0, 1, 1, 6, 0, 0)};
        tbl[5]  = '{8,  mk(1, 1, 1, 1, 1, 1, 0, 1, 0)};
        tbl[6]  = '{15, mk(0, 1, 2, 0, 1, 1, 0, 2, 0)};
        tbl[7]  = '{22, mk(0, 1, 3, 0, 1, 0, 0, 3, 0)};
        tbl[8]  = '{27, mk(0, 6, 3, 0, 0, 0, 5, 3, 0)};
        tbl[9]  = '{29, mk(0, 1, 4, 0, 1, 1, 0, 4, 0)};
        tbl[10] = '{35, mk(1, 0, 0, 0, 1, 1, 6, 4, 0)};
        tbl[11] = '{36, mk(1, 1, 0, 1, 1, 1, 0, 0, 1)};
        tbl[12] = '{37, mk(1, 2, 0, 1, 1, 1, 1, 0, 0)};

        // Reset state on all instances.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_models();

        // First edge after release.
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_de", d_de, 1);
        chk("rel_x", d_x, 0);
        chk("rel_y", d_y, 0);
        chk("rel_fs", d_fs, 1);
        chk("rel_fetch_x", d_fx, 1);
        chk("rel_fetch_y", d_fy, 0);

        // Free run: one default line, two reduced frames.
        de_cnt = 0; de_xmin = 9999; de_xmax = -1;
        hs_cnt = 0; hs_xmin = 9999; hs_xmax = -1; line_per = 0;
        vs_cnt = 0; vs_ymin = 9999; vs_ymax = -1; fs_cnt = 0; fs_per = 0; ychg_bad = 0;
        foreach (de_line[i]) de_line[i] = 1'b0;
        prev_my = m_y;
        prev_dy = d_y;
        for (int c = 0; c < 4100; c++) begin
            check_models();
            if (n <= 1650) begin
                if (d_de) begin
                    de_cnt++;
                    if (int'(d_x) < de_xmin) de_xmin = int'(d_x);
                    if (int'(d_x) > de_xmax) de_xmax = int'(d_x);
                end
                if (d_hs) begin
                    hs_cnt++;
                    if (int'(d_x) < hs_xmin) hs_xmin = int'(d_x);
                    if (int'(d_x) > hs_xmax) hs_xmax = int'(d_x);
                end
            end
            if (n == 1650) begin
                chk("line_end_x", d_x, 1649);
                chk("line_end_y", d_y, 0);
            end
            if (n == 1651) begin
                chk("line_wrap_x", d_x, 0);
                chk("line_wrap_y", d_y, 1);
            end
            if (n > 1 && d_x == 0 && line_per == 0) line_per = n - 1;
            if (n <= 2028) begin
                if (m_vs) begin
                    vs_cnt++;
                    if (int'(m_y) < vs_ymin) vs_ymin = int'(m_y);
                    if (int'(m_y) > vs_ymax) vs_ymax = int'(m_y);
                end
                if (m_de) de_line[m_y[5:0]] = 1'b1;
                if (m_fs) fs_cnt++;
            end
            if (n > 1 && m_fs && fs_per == 0) fs_per = n - 1;
            if (m_y != prev_my && m_x != 0) ychg_bad++;
            if (d_y != prev_dy && d_x != 0) ychg_bad++;
            if (n == 2028) begin
                chk("frame_end_x", m_x, 51);
                chk("frame_end_y", m_y, 38);
            end
            if (n == 2029) begin
                chk("frame_wrap_x", m_x, 0);
                chk("frame_wrap_y", m_y, 0);
                chk("frame_wrap_fs", m_fs, 1);
            end
            prev_my = m_y;
            prev_dy = d_y;
            @(negedge clk);
        end
        mde_lines = 0;
        foreach (de_line[i]) if (de_line[i]) mde_lines++;
        chk("line_de_count", de_cnt, 1280);
        chk("line_de_xmin", de_xmin, 0);
        chk("line_de_xmax", de_xmax, 1279);
        chk("line_hs_count", hs_cnt, 40);
        chk("line_hs_xmin", hs_xmin, 1390);
        chk("line_hs_xmax", hs_xmax, 1429);
        chk("line_period", line_per, 1650);
        chk("frame_vs_count", vs_cnt, 156);
        chk("frame_vs_ymin", vs_ymin, 32);
        chk("frame_vs_ymax", vs_ymax, 34);
        chk("frame_de_lines", mde_lines, 30);
        chk("frame_fs_count", fs_cnt, 1);
        chk("frame_period", fs_per, 2028);
        chk("y_step_only_at_wrap", ychg_bad, 0);

        // Asynchronous reset mid-frame on the reduced instance at (20,15).
        found = 1'b0;
        for (int c = 0; c < 2100 && !found; c++) begin
            if (m_x == 20 && m_y == 15) found = 1'b1;
            else @(negedge clk);
        end
        chk("midreset_reached", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_x_now", m_x, 0);
        chk("midreset_y_now", m_y, 0);
        chk("midreset_de_now", m_de, 0);
        check_models();
        @(negedge clk);
        check_models();
        reset_n = 1'b1;
        @(negedge clk);
        chk("restart_x", m_x, 0);
        chk("restart_y", m_y, 0);
        chk("restart_fs", m_fs, 1);
        chk("restart_de", m_de, 1);
        check_models();

        // Tiny instance vectors after a fresh reset.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            for (int g = 0; g < 100 && n < tbl[i].n; g++) @(negedge clk);
            chk($sformatf("tiny_vec%0d", i), o_tiny, tbl[i].exp);
        end

        // Random run lengths with resets asserted at random points within a cycle.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 300);
            for (int c = 0; c < len; c++) begin
                check_models();
                @(negedge clk);
            end
            #($urandom_range(1, 4));
            reset_n = 1'b0;
            #0.5;
            check_models();
            repeat ($urandom_range(1, 4)) @(negedge clk);
            check_models();
            reset_n = 1'b1;
            @(negedge clk);
        end
        check_models();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
